// File: rtl/hop_mon_pkg.sv
// Shared types and constants for the hop-chain launch/capture monitor.
package hop_mon_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LAUNCH = 3'd1,
    ST_WAIT   = 3'd2,
    ST_CHECK  = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  localparam logic [1:0] ERR_OK      = 2'd0;
  localparam logic [1:0] ERR_LATENCY = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT = 2'd2;
  localparam logic [1:0] ERR_GLITCH  = 2'd3;

  localparam logic [7:0] SAT_MAX = 8'd255;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == SAT_MAX) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/hop_chain_monitor_if.sv
// Control/result bundle between the hop-chain monitor and its environment.
interface hop_chain_monitor_if #(
  parameter int CNT_W = 8
);
  logic             go;
  logic             chain_in;
  logic             chain_start;
  logic             busy;
  logic             done;
  logic             pass;
  logic [1:0]       err;
  logic [CNT_W-1:0] latency;
  logic [7:0]       pass_cnt;
  logic [7:0]       fail_cnt;

  modport master (
    output go, chain_in,
    input  chain_start, busy, done, pass, err, latency, pass_cnt, fail_cnt
  );

  modport slave (
    input  go, chain_in,
    output chain_start, busy, done, pass, err, latency, pass_cnt, fail_cnt
  );
endinterface

// File: rtl/hop_sat_cnt.sv
// 8-bit saturating event counter with asynchronous active-low clear.
module hop_sat_cnt
  import hop_mon_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_clr_n,
  input  logic       i_inc,
  output logic [7:0] o_cnt
);
  logic [7:0] r_cnt;

  // Count up on each enabled cycle, sticking at the maximum.
  always_ff @(posedge i_clk or negedge i_clr_n) begin
    if (!i_clr_n) begin
      r_cnt <= 8'd0;
    end else if (i_inc) begin
      r_cnt <= sat_inc(r_cnt);
    end else begin
      r_cnt <= r_cnt;
    end
  end

  assign o_cnt = r_cnt;
endmodule

// File: rtl/hop_chain_monitor.sv
// Launches a one-cycle pulse into a flop chain, times its return on chain_in
// and grades the hop latency against EXP_HOPS.
module hop_chain_monitor
  import hop_mon_pkg::*;
#(
  parameter int EXP_HOPS = 4,
  parameter int TIMEOUT  = 16,
  parameter int CNT_W    = 8
) (
  input  logic               clock0,
  input  logic               rst_n,
  hop_chain_monitor_if.slave bus
);
  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] EXP_C     = CNT_W'(EXP_HOPS);
  localparam logic [CNT_W-1:0] ONE_C     = CNT_W'(1);
  localparam logic [CNT_W-1:0] ZERO_C    = {CNT_W{1'b0}};

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [CNT_W-1:0] r_latency;
  logic [CNT_W-1:0] w_latency_nxt;
  logic [1:0]       r_err;
  logic [1:0]       w_err_nxt;
  logic             r_pass;
  logic             w_pass_nxt;
  logic             r_chain_start;
  logic             r_busy;
  logic             r_done;
  logic             w_inc_pass;
  logic             w_inc_fail;
  logic [7:0]       w_pass_cnt;
  logic [7:0]       w_fail_cnt;

  // State register.
  always_ff @(posedge clock0 or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state, cycle counter and result update.
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_latency_nxt = r_latency;
    w_err_nxt     = r_err;
    w_pass_nxt    = r_pass;
    case (r_state)
      ST_IDLE: begin
        if (bus.go) begin
          w_state_nxt   = ST_LAUNCH;
          w_cnt_nxt     = ZERO_C;
          w_latency_nxt = ZERO_C;
          w_err_nxt     = ERR_OK;
          w_pass_nxt    = 1'b0;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_LAUNCH: begin
        // chain_in already high while we launch cannot be our pulse.
        if (bus.chain_in) begin
          w_err_nxt   = ERR_GLITCH;
          w_state_nxt = ST_DONE;
        end else begin
          w_cnt_nxt   = r_cnt + ONE_C;
          w_state_nxt = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (bus.chain_in) begin
          w_latency_nxt = r_cnt;
          w_state_nxt   = ST_CHECK;
        end else if (r_cnt == TIMEOUT_C) begin
          w_err_nxt     = ERR_TIMEOUT;
          w_latency_nxt = TIMEOUT_C;
          w_state_nxt   = ST_DONE;
        end else begin
          w_cnt_nxt = r_cnt + ONE_C;
        end
      end
      ST_CHECK: begin
        if (bus.chain_in) begin
          w_err_nxt = ERR_GLITCH;
        end else if (r_latency != EXP_C) begin
          w_err_nxt = ERR_LATENCY;
        end else begin
          w_pass_nxt = 1'b1;
        end
        w_state_nxt = ST_DONE;
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Registered datapath and flop-driven status outputs.
  always_ff @(posedge clock0 or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt         <= ZERO_C;
      r_latency     <= ZERO_C;
      r_err         <= ERR_OK;
      r_pass        <= 1'b0;
      r_chain_start <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
    end else begin
      r_cnt         <= w_cnt_nxt;
      r_latency     <= w_latency_nxt;
      r_err         <= w_err_nxt;
      r_pass        <= w_pass_nxt;
      r_chain_start <= (w_state_nxt == ST_LAUNCH);
      r_busy        <= (w_state_nxt != ST_IDLE);
      r_done        <= (w_state_nxt == ST_DONE);
    end
  end

  assign w_inc_pass = (r_state == ST_DONE) &&  r_pass;
  assign w_inc_fail = (r_state == ST_DONE) && !r_pass;

  hop_sat_cnt u_pass_cnt (
    .i_clk   (clock0),
    .i_clr_n (rst_n),
    .i_inc   (w_inc_pass),
    .o_cnt   (w_pass_cnt)
  );

  hop_sat_cnt u_fail_cnt (
    .i_clk   (clock0),
    .i_clr_n (rst_n),
    .i_inc   (w_inc_fail),
    .o_cnt   (w_fail_cnt)
  );

  assign bus.chain_start = r_chain_start;
  assign bus.busy        = r_busy;
  assign bus.done        = r_done;
  assign bus.pass        = r_pass;
  assign bus.err         = r_err;
  assign bus.latency     = r_latency;
  assign bus.pass_cnt    = w_pass_cnt;
  assign bus.fail_cnt    = w_fail_cnt;
endmodule

// File: tb/tb_hop_chain_monitor.sv
// Scoreboard bench for hop_chain_monitor: directed runs against a flop-chain
// model, results checked by an independent monitor process.
module tb_hop_chain_monitor;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  hop_chain_monitor_if #(.CNT_W(8)) bus ();

  hop_chain_monitor #(.EXP_HOPS(4), .TIMEOUT(16), .CNT_W(8)) dut (
    .clock0 (clk),
    .rst_n  (rst_n),
    .bus    (bus.slave)
  );

  typedef struct {
    logic       pass;
    logic [1:0] err;
    int         lat;
    int         dcyc;
    int         pcnt;
    int         fcnt;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   launches = 0;
  int   m_pass = 0;
  int   m_fail = 0;
  int   chain_len = 4;
  bit   wide = 1'b0;
  bit   force_hi = 1'b0;
  bit   tie_low = 1'b0;
  logic [7:0] sh = 8'd0;

  always @(posedge clk) cyc <= cyc + 1;

  // Flop chain under test: chain_in is the output of stage chain_len.
  always @(posedge clk) sh <= {sh[6:0], bus.chain_start};

  always_comb begin
    bus.chain_in = 1'b0;
    if (!tie_low)
      bus.chain_in = force_hi | sh[chain_len-1] | (wide & sh[chain_len]);
  end

  task automatic chk(input string nm, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, req);
    end
  endtask

  task automatic push_exp(input bit ep, input int ee, input int el, input int ed);
    exp_t e;
    if (ep) m_pass = (m_pass < 255) ? m_pass + 1 : 255;
    else    m_fail = (m_fail < 255) ? m_fail + 1 : 255;
    e.pass = ep;
    e.err  = ee[1:0];
    e.lat  = el;
    e.dcyc = ed;
    e.pcnt = m_pass;
    e.fcnt = m_fail;
    exp_q.push_back(e);
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (bus.done) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL done_timeout actual=no_done required=done_within_%0d_cycles", budget);
    end
  endtask

  task automatic run_vec(input int len_i, input bit wide_i, input bit fh_i, input bit tl_i,
                         input bit ep, input int ee, input int el, input int ed,
                         input int go_at);
    bit ok;
    chain_len = len_i;
    wide      = wide_i;
    force_hi  = fh_i;
    tie_low   = tl_i;
    push_exp(ep, ee, el, ed);
    @(negedge clk); bus.go = 1'b1;
    @(negedge clk); bus.go = 1'b0;
    if (go_at > 0) begin
      repeat (go_at) @(negedge clk);
      bus.go = 1'b1;
      @(negedge clk); bus.go = 1'b0;
    end
    wait_done(40, ok);
    force_hi = 1'b0;
    tie_low  = 1'b0;
    wide     = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_chain_start"}, bus.chain_start, 0);
    chk({tag, "_busy"},        bus.busy,        0);
    chk({tag, "_done"},        bus.done,        0);
    chk({tag, "_pass"},        bus.pass,        0);
    chk({tag, "_err"},         bus.err,         0);
    chk({tag, "_latency"},     bus.latency,     0);
    chk({tag, "_pass_cnt"},    bus.pass_cnt,    0);
    chk({tag, "_fail_cnt"},    bus.fail_cnt,    0);
  endtask

  // Monitor: tracks launches and grades every done strobe against the queue.
  initial begin : monitor
    exp_t e;
    int   launch_cyc = 0;
    int   cs_w = 0;
    int   pc = 0;
    int   fc = 0;
    bit   prev_cs = 1'b0;
    bit   pend = 1'b0;
    forever begin
      @(negedge clk);
      if (pend) begin
        chk("pass_cnt", bus.pass_cnt, pc);
        chk("fail_cnt", bus.fail_cnt, fc);
        pend = 1'b0;
      end
      if (bus.chain_start) begin
        if (!prev_cs) begin
          launch_cyc = cyc;
          cs_w = 0;
          launches++;
        end
        cs_w++;
      end
      prev_cs = bus.chain_start;
      if (bus.done) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("pass",        bus.pass,         e.pass);
          chk("err",         bus.err,          e.err);
          chk("latency",     bus.latency,      e.lat);
          chk("done_cycle",  cyc - launch_cyc, e.dcyc);
          chk("start_width", cs_w,             1);
          chk("busy_at_done", bus.busy,        1);
          pc = e.pcnt;
          fc = e.fcnt;
          pend = 1'b1;
        end
      end
    end
  end

  initial begin : stim
    int n0;
    bit ok;
    rst_n  = 1'b0;
    bus.go = 1'b0;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    //      len wide fh tl  pass err lat dcyc go_at
    run_vec(4,  0,   0, 0,  1,   0,  4,  6,   0);   // nominal pass
    run_vec(3,  0,   0, 0,  0,   1,  3,  5,   0);   // short chain
    run_vec(4,  0,   0, 1,  0,   2,  16, 17,  0);   // timeout
    run_vec(4,  0,   1, 0,  0,   3,  0,  1,   0);   // chain_in high at launch
    run_vec(4,  1,   0, 0,  0,   3,  4,  6,   0);   // 2-cycle-wide return
    run_vec(5,  0,   0, 0,  0,   1,  5,  7,   0);   // long chain

    n0 = launches;
    run_vec(4,  0,   0, 0,  1,   0,  4,  6,   2);   // go pulsed in WAIT
    chk("go_ignored_launches", launches, n0 + 1);

    // Reset in the middle of a run drops everything at once.
    chain_len = 4;
    @(negedge clk); bus.go = 1'b1;
    @(negedge clk); bus.go = 1'b0;
    repeat (2) @(negedge clk);
    chk("busy_before_reset", bus.busy, 1);
    #1 rst_n = 1'b0;
    #1;
    chk_all_zero("midrun_reset");
    m_pass = 0;
    m_fail = 0;
    repeat (10) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    run_vec(4,  0,   0, 0,  1,   0,  4,  6,   0);   // clean pass after reset

    // Saturation: 256 back-to-back passing runs with go held high.
    for (int i = 0; i < 256; i++) push_exp(1'b1, 0, 4, 6);
    @(negedge clk); bus.go = 1'b1;
    for (int i = 0; i < 256; i++) begin
      wait_done(40, ok);
      if (!ok) break;
    end
    bus.go = 1'b0;
    repeat (6) @(negedge clk);
    chk("sat_pass_cnt", bus.pass_cnt, 255);
    chk("sat_fail_cnt", bus.fail_cnt, 0);
    chk("queue_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/hop_chain_monitor.md
# hop_chain_monitor

Launch-and-capture monitor for the hop-chain micro-benchmarks. It fires a single-cycle `chain_start` pulse into a flip-flop chain under test and captures the pulse returning from the chain's last stage. It then measures the hop latency and checks it against an expected count, flagging timeouts and malformed pulses. It sits on the same `clock0` domain as the chain and serves as the receiving end of the chain's `start`→last-flop path.

## Interface
Parameters:
- `EXP_HOPS`, default 4: expected latency in cycles from `chain_start` to `chain_in`.
- `TIMEOUT`, default 16: maximum cycles to wait for `chain_in`. Must be less than 2^`CNT_W` and greater than `EXP_HOPS`.
- `CNT_W`, default 8: width of the latency counter and of `latency`.

Ports:
- `clock0  in  1`: single clock; all logic is on its rising edge.
- `rst_n  in  1`: asynchronous, active-low reset.
- `go  in  1`: request a run; sampled only in IDLE.
- `chain_in  in  1`: output of the chain's last stage; same clock domain, no synchronizer.
- `chain_start  out  1`: registered launch pulse into the chain.
- `busy  out  1`: high from LAUNCH through DONE inclusive.
- `done  out  1`: one-cycle strobe; result outputs are valid from this cycle onward.
- `pass  out  1`: last run passed; held until the next launch.
- `err  out  2`: 0 = OK, 1 = LATENCY, 2 = TIMEOUT, 3 = GLITCH; held until the next launch.
- `latency  out  CNT_W`: measured latency of the last run; held.
- `pass_cnt  out  8`: saturating count of passed runs.
- `fail_cnt  out  8`: saturating count of failed runs.

## Operation
- States: IDLE, LAUNCH, WAIT, CHECK, DONE.
- **IDLE**
  - `go`=1 moves to LAUNCH.
  - `pass`, `err` and `latency` are cleared on entry to LAUNCH.
- **LAUNCH** (cycle 0)
  - `chain_start`=1 for this cycle only, and the counter is set to 0.
  - `chain_in`=1 sampled here sets `err`=GLITCH and moves to DONE.
  - Otherwise the FSM moves to WAIT.
- **WAIT** (cycles 1..)
  - The counter increments each cycle, so it equals the cycle number.
  - `chain_in`=1 at cycle k captures `latency`=k and moves to CHECK.
  - If the counter reaches `TIMEOUT` with `chain_in`=0, then `err`=TIMEOUT, `latency`=`TIMEOUT`, and the FSM moves to DONE.
  - If `chain_in` is high in the same cycle the counter reaches `TIMEOUT`, the capture wins.
- **CHECK** (cycle k+1)
  - `chain_in` still 1: the pulse is wider than one cycle, so `err`=GLITCH.
  - Else if `latency`≠`EXP_HOPS`: `err`=LATENCY.
  - Else: `pass`=1.
  - The FSM always moves to DONE.
- **DONE**
  - `done`=1 for one cycle.
  - `pass_cnt` increments if `pass`=1, otherwise `fail_cnt` increments. Both saturate at 255.
  - The FSM then returns to IDLE.
- `go` in any state other than IDLE is ignored and is not queued.
- Reset values: every output is 0 and the state is IDLE.
  - Reset asserted mid-run drops `chain_start` and `busy` asynchronously and loses the run.
  - Counters are cleared by reset only.

## Timing
- Result latency is k+2 cycles after LAUNCH for a capture at cycle k. For a 4-hop chain, `done` occurs at cycle 6.
- Timeout path: `done` at cycle `TIMEOUT`+1.
- GLITCH at launch: `done` at cycle 1.
- Back-to-back runs: `go` held high gives a new LAUNCH 2 cycles after `done` (one cycle in IDLE between runs).
- `chain_start` comes straight from a flop, with no combinational path from `go` or `chain_in`.

## Structure
- Package `hop_mon_pkg` holds:
  - the state enum;
  - the `err` code constants `ERR_OK`, `ERR_LATENCY`, `ERR_TIMEOUT`, `ERR_GLITCH`;
  - the counter saturation constant (255).
- Sub-module `hop_sat_cnt`: 8-bit saturating increment counter with async active-low clear. It is instantiated twice, for `pass_cnt` and `fail_cnt`.
- FSM, latency counter and result registers live in the top level.

## Test plan
- **Nominal pass:** 4-flop chain model, `go` for one cycle → `chain_start` high at cycle 0 only, `chain_in` high at cycle 4, `done` at cycle 6, `pass`=1, `err`=0, `latency`=4, `pass_cnt`=1.
- **Latency mismatch:** 3-flop chain, `EXP_HOPS`=4 → `latency`=3, `err`=1, `pass`=0, `fail_cnt`=1, `done` at cycle 5.
- **Timeout:** `chain_in` tied low, `TIMEOUT`=16 → `done` at cycle 17, `err`=2, `latency`=16.
- **Glitch:**
  - `chain_in` high at launch → `err`=3 with `done` at cycle 1.
  - A 2-cycle-wide returning pulse → `err`=3, `latency`=4.
- **Control edge cases:**
  - `go` pulsed during WAIT → ignored.
  - `rst_n` low during WAIT → all outputs 0 immediately; the next `go` produces a clean pass.
- **Saturation:** 256 consecutive passing runs → `pass_cnt` stays at 255 and `fail_cnt`=0.
